add_sub_scheduler: RTL and testbench



---
 rtl/add_sub_scheduler.sv | 155 +++++++++++++++
 tb/tb_add_sub_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : add_sub_scheduler
//  Purpose  : Shares one up/down step accumulator between two requesters.
//             A round-robin arbiter accepts one {dir, steps} command at a
//             time over a valid/ready handshake. A three-state FSM then
//             applies that command as one +/-1 step per clock.
//  Options  : ADD_SUB_SCHEDULER_SATURATE_EN - clamp at 0 / 2^WIDTH-1
//             instead of wrapping modulo 2^WIDTH.
//  Revision : 1.0 - initial release
// ============================================================================
module add_sub_scheduler #(
  parameter int WIDTH   = 4,
  parameter int STEPS_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  input  logic               req0_valid_i,
  input  logic               req0_dir_i,
  input  logic [STEPS_W-1:0] req0_steps_i,
  output logic               req0_ready_o,
  input  logic               req1_valid_i,
  input  logic               req1_dir_i,
  input  logic [STEPS_W-1:0] req1_steps_i,
  output logic               req1_ready_o,
  output logic [WIDTH-1:0]   value_o,
  output logic               busy_o,
  output logic               grant_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   C_VAL_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]   C_VAL_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   C_VAL_ZERO = '0;
  localparam logic [STEPS_W-1:0] C_STP_ONE  = STEPS_W'(1);
  localparam logic [STEPS_W-1:0] C_STP_ZERO = '0;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [STEPS_W-1:0] remaining_q, remaining_d;
  logic               dir_q, dir_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;

  logic               w_sel;
  logic               w_sel_valid;
  logic               w_sel_dir;
  logic [STEPS_W-1:0] w_sel_steps;
  logic               w_accept;

  // One step of the accumulator; clamps instead of wrapping when saturation
  // is compiled in, but always occupies exactly one cycle either way.
  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] v,
                                               input logic             sub);
    logic [WIDTH-1:0] r;
`ifdef ADD_SUB_SCHEDULER_SATURATE_EN
    if (!sub) r = (v == C_VAL_MAX)  ? v : v + C_VAL_ONE;
    else      r = (v == C_VAL_ZERO) ? v : v - C_VAL_ONE;
`else
    if (!sub) r = v + C_VAL_ONE;
    else      r = v - C_VAL_ONE;
`endif
    return r;
  endfunction

  // Arbitration: a lone valid wins; on a tie the requester not served last wins.
  always_comb begin
    w_sel       = 1'b0;
    w_sel_valid = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) w_sel = ~last_q;
    else if (req1_valid_i)            w_sel = 1'b1;
    w_sel_dir   = w_sel ? req1_dir_i   : req0_dir_i;
    w_sel_steps = w_sel ? req1_steps_i : req0_steps_i;
    // Reset gating keeps ready low while the block is held in reset; clear
    // suppresses any handshake in its cycle.
    w_accept    = reset_ni && (state_q == S_IDLE) && !clear_i && w_sel_valid;
  end

  assign req0_ready_o = w_accept && !w_sel;
  assign req1_ready_o = w_accept &&  w_sel;

  // Next-state, accumulator and command bookkeeping.
  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    grant_d     = grant_q;
    last_d      = last_q;

    if (clear_i) begin
      // Clear beats everything; arbitration history is deliberately kept.
      state_d     = S_IDLE;
      value_d     = C_VAL_ZERO;
      remaining_d = C_STP_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            dir_d       = w_sel_dir;
            remaining_d = w_sel_steps;
            grant_d     = w_sel;
            last_d      = w_sel;
            state_d     = (w_sel_steps == C_STP_ZERO) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          value_d     = step_fn(value_q, dir_q);
          remaining_d = remaining_q - C_STP_ONE;
          if (remaining_q == C_STP_ONE) state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset aborts any command immediately.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      value_q     <= C_VAL_ZERO;
      remaining_q <= C_STP_ZERO;
      dir_q       <= 1'b0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
    end
  end

  assign value_o = value_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
  // A clear landing on the DONE cycle swallows the pulse.
  assign done_o  = (state_q == S_DONE) && !clear_i;

endmodule
`default_nettype wire

// File: tb/tb_add_sub_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_sub_scheduler
//  Purpose  : Self-checking bench for add_sub_scheduler. Directed scenarios
//             followed by random traffic, compared against a command-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_add_sub_scheduler;

  localparam int WIDTH   = 4;
  localparam int STEPS_W = 4;
  localparam int MODV    = 1 << WIDTH;

  logic               clk = 1'b0;
  logic               reset_ni = 1'b0;
  logic               clear_i = 1'b0;
  logic               req0_valid_i = 1'b0, req0_dir_i = 1'b0;
  logic [STEPS_W-1:0] req0_steps_i = '0;
  logic               req1_valid_i = 1'b0, req1_dir_i = 1'b0;
  logic [STEPS_W-1:0] req1_steps_i = '0;
  logic               req0_ready_o, req1_ready_o;
  logic [WIDTH-1:0]   value_o;
  logic               busy_o, grant_o, done_o;

  add_sub_scheduler #(.WIDTH(WIDTH), .STEPS_W(STEPS_W)) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .clear_i      (clear_i),
    .req0_valid_i (req0_valid_i),
    .req0_dir_i   (req0_dir_i),
    .req0_steps_i (req0_steps_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_dir_i   (req1_dir_i),
    .req1_steps_i (req1_steps_i),
    .req1_ready_o (req1_ready_o),
    .value_o      (value_o),
    .busy_o       (busy_o),
    .grant_o      (grant_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (command level) ----------------
  int cyc    = 0;
  bit act    = 0;   // a command is in flight
  int t_acc  = 0;   // cycle of acceptance
  int m_n    = 0;   // step count of the command
  bit m_dir  = 0;
  int m_start = 0;  // accumulator value when the command was accepted
  int m_val  = 0;   // accumulator value while idle
  bit m_grant = 0;
  bit m_last  = 1;

  // Value after applying n unit steps from s in one direction.
  function automatic int apply_steps(input int s, input bit d, input int n);
    int r;
    r = d ? s - n : s + n;
`ifdef ADD_SUB_SCHEDULER_SATURATE_EN
    if (r < 0)        r = 0;
    if (r > MODV - 1) r = MODV - 1;
`else
    r = ((r % MODV) + MODV) % MODV;
`endif
    return r;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    act = 0; m_val = 0; m_grant = 0; m_last = 1;
  endtask

  // One clock: drive inputs after the edge, check mid-cycle, advance model.
  task automatic cycle(input bit v0, input bit d0, input int s0,
                       input bit v1, input bit d1, input int s1,
                       input bit clr);
    int k, e_val, sel;
    bit e_busy, e_done, e_r0, e_r1;
    @(posedge clk);
    #1;
    req0_valid_i = v0; req0_dir_i = d0; req0_steps_i = STEPS_W'(s0);
    req1_valid_i = v1; req1_dir_i = d1; req1_steps_i = STEPS_W'(s1);
    clear_i = clr;
    #3;
    e_r0 = 0; e_r1 = 0; sel = -1; k = 0;
    if (act) begin
      k      = cyc - t_acc;
      e_busy = 1;
      e_done = (k == m_n + 1) && !clr;
      e_val  = apply_steps(m_start, m_dir, min2(k - 1, m_n));
    end else begin
      e_busy = 0;
      e_done = 0;
      e_val  = m_val;
      if (!clr) begin
        if (v0 && v1) sel = m_last ? 0 : 1;
        else if (v0)  sel = 0;
        else if (v1)  sel = 1;
      end
      e_r0 = (sel == 0);
      e_r1 = (sel == 1);
    end
    chk("ready0", int'(req0_ready_o), int'(e_r0));
    chk("ready1", int'(req1_ready_o), int'(e_r1));
    chk("value",  int'(value_o),      e_val);
    chk("busy",   int'(busy_o),       int'(e_busy));
    chk("done",   int'(done_o),       int'(e_done));
    chk("grant",  int'(grant_o),      int'(m_grant));
    // advance to the next cycle
    if (clr) begin
      act = 0; m_val = 0;
    end else if (act) begin
      if (k == m_n + 1) begin
        act = 0; m_val = apply_steps(m_start, m_dir, m_n);
      end
    end else if (sel >= 0) begin
      act = 1; t_acc = cyc; m_start = m_val;
      m_n   = (sel == 0) ? s0 : s1;
      m_dir = (sel == 0) ? d0 : d1;
      m_grant = sel[0]; m_last = sel[0];
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(posedge clk);
    #2;
    req0_valid_i = 1; req1_valid_i = 1;
    #1;
    chk("rst_value", int'(value_o), 0);
    chk("rst_busy",  int'(busy_o), 0);
    chk("rst_done",  int'(done_o), 0);
    chk("rst_grant", int'(grant_o), 0);
    chk("rst_ready0", int'(req0_ready_o), 0);
    chk("rst_ready1", int'(req1_ready_o), 0);
    req0_valid_i = 0; req1_valid_i = 0;
    @(posedge clk); #1 reset_ni = 1;
    model_reset();

    // ---- req0 add 5 ----
    cycle(1, 0, 5, 0, 0, 0, 0);
    idle(8);

    // ---- contention, one step each, held ----
    for (int i = 0; i < 12; i++) cycle(1, 0, 1, 1, 0, 1, 0);
    idle(2);

    // ---- reach 2, then req1 subtract 4 (wrap / clamp through zero) ----
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 2, 0, 0, 0, 0);
    idle(4);
    cycle(0, 0, 0, 1, 1, 4, 0);
    idle(6);

    // ---- zero-step command, back to back ----
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    idle(2);

    // ---- clear during RUN at step 2 of 6 with req1 pending ----
    cycle(1, 0, 6, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 3, 0);
    cycle(0, 0, 0, 1, 1, 3, 0);
    cycle(0, 0, 0, 1, 1, 3, 1);
    cycle(0, 0, 0, 1, 1, 3, 0);
    idle(6);

    // ---- saturation/wrap at the top ----
    cycle(1, 0, 15, 0, 0, 0, 0);
    idle(17);
    cycle(0, 0, 0, 1, 0, 3, 0);
    idle(5);

    // ---- asynchronous reset mid-RUN, then tie goes to requester 0 ----
    cycle(0, 0, 0, 1, 0, 7, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    #1 reset_ni = 0;
    #1;
    chk("arst_value", int'(value_o), 0);
    chk("arst_busy",  int'(busy_o), 0);
    chk("arst_done",  int'(done_o), 0);
    @(posedge clk); #1;
    chk("arst_hold_value", int'(value_o), 0);
    req0_valid_i = 0; req1_valid_i = 0; clear_i = 0;
    reset_ni = 1;
    model_reset();
    cycle(1, 0, 1, 1, 1, 1, 0);
    idle(4);

    // ---- random traffic ----
    for (int i = 0; i < 1500; i++) begin
      bit v0, v1, d0, d1, clr;
      int s0, s1;
      v0  = ($urandom_range(0, 2) != 0);
      v1  = ($urandom_range(0, 2) != 0);
      d0  = $urandom_range(0, 1);
      d1  = $urandom_range(0, 1);
      s0  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      s1  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      clr = ($urandom_range(0, 39) == 0);
      cycle(v0, d0, s0, v1, d1, s1, clr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
